// File: rtl/clock_pkg.sv
// Shared widths, limits and controller mode encodings for the clock datapath,
// controller and display, so every block agrees on field sizes and terminal counts.
package clock_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
  localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;
  localparam logic [SEC_W-1:0]  MAX_SEC  = 6'd59;

  typedef enum logic [1:0] {
    MODE_RUN       = 2'd0,
    MODE_SET_HOUR  = 2'd1,
    MODE_SET_MIN   = 2'd2,
    MODE_SET_ALARM = 2'd3
  } clock_mode_e;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to a one-per-second wrap pulse and a registered
// half-second blink flag. The wrap output is combinational and asserts in the cycle before the wrap edge.
module tick_prescaler #(
  parameter int CYCLES_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic wrap,
  output logic half_sec
);

  localparam int CNT_W = $clog2(CYCLES_PER_SEC);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES_PER_SEC - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CYCLES_PER_SEC / 2);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  assign wrap = en && (cnt == LAST);

  always_comb begin
    cnt_next = cnt;
    if (clear)
      cnt_next = '0;
    else if (en)
      cnt_next = wrap ? '0 : cnt + 1'b1;
  end

  // half_sec is derived from the value being loaded so it stays in lockstep with cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      half_sec <= 1'b1;
    end else begin
      cnt      <= cnt_next;
      half_sec <= (cnt_next < HALF);
    end
  end

endmodule

// File: rtl/rtc_time_counter.sv
// Real-time clock datapath: sec/min/hour cascade driven by the 1 Hz prescaler,
// validated loads from the controller, and single-cycle carry strobes.
module rtc_time_counter
  import clock_pkg::*;
#(
  parameter int CYCLES_PER_SEC = 50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              count_en,
  input  logic              load_en,
  input  logic [HOUR_W-1:0] hour_load,
  input  logic [MIN_W-1:0]  min_load,
  output logic [HOUR_W-1:0] hour,
  output logic [MIN_W-1:0]  min,
  output logic [SEC_W-1:0]  sec,
  output logic              sec_tick,
  output logic              min_carry,
  output logic              hour_carry,
  output logic              day_rollover,
  output logic              half_sec,
  output logic              load_err
);

  logic wrap;
  logic hour_ok;
  logic min_ok;

  tick_prescaler #(
    .CYCLES_PER_SEC(CYCLES_PER_SEC)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (count_en),
    .clear    (load_en),
    .wrap     (wrap),
    .half_sec (half_sec)
  );

  assign hour_ok = (hour_load <= MAX_HOUR);
  assign min_ok  = (min_load <= MAX_MIN);

  // NOTE: all state here uses non-blocking assignments so every register samples
  // pre-edge values; blocking would let the carry logic see already-updated fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      hour         <= '0;
      min          <= '0;
      sec          <= '0;
      sec_tick     <= 1'b0;
      min_carry    <= 1'b0;
      hour_carry   <= 1'b0;
      day_rollover <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      sec_tick     <= 1'b0;
      min_carry    <= 1'b0;
      hour_carry   <= 1'b0;
      day_rollover <= 1'b0;
      load_err     <= 1'b0;
      if (load_en) begin
        // A load wins over a coincident wrap; invalid fields keep their old value.
        sec      <= '0;
        load_err <= !(hour_ok && min_ok);
        if (hour_ok) hour <= hour_load;
        if (min_ok)  min  <= min_load;
      end else if (wrap) begin
        sec_tick <= 1'b1;
        if (sec == MAX_SEC) begin
          sec       <= '0;
          min_carry <= 1'b1;
          if (min == MAX_MIN) begin
            min        <= '0;
            hour_carry <= 1'b1;
            if (hour == MAX_HOUR) begin
              hour         <= '0;
              day_rollover <= 1'b1;
            end else begin
              hour <= hour + 1'b1;
            end
          end else begin
            min <= min + 1'b1;
          end
        end else begin
          sec <= sec + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rtc_time_counter.sv
// Self-checking bench for rtc_time_counter: directed scenarios plus random stimulus
// compared against a seconds-of-day reference model.
module tb_rtc_time_counter;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       count_en = 1'b0;
  logic       load_en = 1'b0;
  logic [4:0] hour_load = '0;
  logic [5:0] min_load = '0;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic       sec_tick, min_carry, hour_carry, day_rollover, half_sec, load_err;

  int errors = 0;
  int checks = 0;

  // Reference model: time as seconds of the day, prescaler as a plain integer.
  int m_t = 0;
  int m_p = 0;
  bit m_half = 1'b1;
  bit m_tick, m_mc, m_hc, m_dr, m_err;

  rtc_time_counter #(.CYCLES_PER_SEC(C)) dut (
    .clk          (clk),
    .rst          (rst),
    .count_en     (count_en),
    .load_en      (load_en),
    .hour_load    (hour_load),
    .min_load     (min_load),
    .hour         (hour),
    .min          (min),
    .sec          (sec),
    .sec_tick     (sec_tick),
    .min_carry    (min_carry),
    .hour_carry   (hour_carry),
    .day_rollover (day_rollover),
    .half_sec     (half_sec),
    .load_err     (load_err)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    int h, m;
    m_tick = 0; m_mc = 0; m_hc = 0; m_dr = 0; m_err = 0;
    if (rst) begin
      m_t = 0; m_p = 0; m_half = 1;
    end else if (load_en) begin
      h = m_t / 3600;
      m = (m_t / 60) % 60;
      if (int'(hour_load) <= 23) h = int'(hour_load);
      if (int'(min_load) <= 59)  m = int'(min_load);
      m_err  = (int'(hour_load) > 23) || (int'(min_load) > 59);
      m_t    = h * 3600 + m * 60;
      m_p    = 0;
      m_half = 1;
    end else if (count_en) begin
      if (m_p == C - 1) begin
        m_p    = 0;
        m_t    = (m_t + 1) % 86400;
        m_tick = 1;
        m_mc   = (m_t % 60 == 0);
        m_hc   = (m_t % 3600 == 0);
        m_dr   = (m_t == 0);
      end else begin
        m_p++;
      end
      m_half = (m_p < C / 2);
    end
  endtask

  function automatic logic [22:0] expected();
    return {5'(m_t / 3600), 6'((m_t / 60) % 60), 6'(m_t % 60),
            m_tick, m_mc, m_hc, m_dr, m_half, m_err};
  endfunction

  function automatic logic [22:0] observed();
    return {hour, min, sec, sec_tick, min_carry, hour_carry, day_rollover, half_sec, load_err};
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1; count_en = 1; load_en = 0;
    cycle();
    cycle();
    checks++;
    if (observed() !== 23'b00000_000000_000000_000010) begin
      errors++;
      $display("FAIL reset_state got=%h want=%h", observed(), 23'b00000_000000_000000_000010);
    end
    rst = 0; count_en = 0;
    cycle();
    checks++;
    if (observed() !== expected()) begin
      errors++;
      $display("FAIL reset_hold got=%h want=%h", observed(), expected());
    end
  endtask

  task automatic test_count();
    int ticks = 0, mc_seen = 0, mc_at = -1;
    count_en = 1;
    for (int i = 1; i <= 240; i++) begin
      cycle();
      if (sec_tick === 1'b1) ticks++;
      if (min_carry === 1'b1) begin mc_seen++; mc_at = i; end
      checks++;
      if (sec_tick !== ((i % C) == 0) || half_sec !== ((i % C) < C / 2)) begin
        errors++;
        $display("FAIL count_pattern cycle=%0d got tick=%b half=%b want tick=%b half=%b",
                 i, sec_tick, half_sec, (i % C) == 0, (i % C) < C / 2);
      end
    end
    checks++;
    if (min !== 6'd1 || sec !== 6'd0 || ticks != 60) begin
      errors++;
      $display("FAIL count_60 got min=%0d sec=%0d ticks=%0d want min=1 sec=0 ticks=60", min, sec, ticks);
    end
    checks++;
    if (mc_seen != 1 || mc_at != 240) begin
      errors++;
      $display("FAIL count_min_carry got seen=%0d at=%0d want seen=1 at=240", mc_seen, mc_at);
    end
  endtask

  task automatic test_rollover();
    load_en = 1; hour_load = 5'd23; min_load = 6'd59;
    cycle();
    load_en = 0;
    checks++;
    if (hour !== 5'd23 || min !== 6'd59 || sec !== 6'd0) begin
      errors++;
      $display("FAIL rollover_load got %0d:%0d:%0d want 23:59:0", hour, min, sec);
    end
    for (int i = 1; i <= 240; i++) begin
      cycle();
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL rollover_run cycle=%0d got=%h want=%h", i, observed(), expected());
      end
    end
    checks++;
    if (observed() !== 23'b00000_000000_000000_111110) begin
      errors++;
      $display("FAIL rollover_final got=%h want=%h", observed(), 23'b00000_000000_000000_111110);
    end
  endtask

  task automatic test_pause();
    logic [5:0] sec_s;
    logic       half_s;
    count_en = 1;
    cycle();
    cycle();
    checks++;
    if (m_p != 2 || half_sec !== 1'b0) begin
      errors++;
      $display("FAIL pause_setup got model_p=%0d half=%b want p=2 half=0", m_p, half_sec);
    end
    sec_s = sec; half_s = half_sec;
    count_en = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++;
      if (sec !== sec_s || half_sec !== half_s ||
          {sec_tick, min_carry, hour_carry, day_rollover} !== 4'b0) begin
        errors++;
        $display("FAIL pause_hold cycle=%0d got sec=%0d half=%b strobes=%b want sec=%0d half=%b strobes=0",
                 i, sec, half_sec, {sec_tick, min_carry, hour_carry, day_rollover}, sec_s, half_s);
      end
    end
    count_en = 1;
    cycle();
    checks++;
    if (sec_tick !== 1'b0) begin
      errors++;
      $display("FAIL pause_resume1 got tick=%b want 0", sec_tick);
    end
    cycle();
    checks++;
    if (sec_tick !== 1'b1 || sec !== sec_s + 6'd1) begin
      errors++;
      $display("FAIL pause_resume2 got tick=%b sec=%0d want tick=1 sec=%0d", sec_tick, sec, sec_s + 6'd1);
    end
  endtask

  task automatic test_load_on_wrap();
    count_en = 1;
    load_en = 1; hour_load = 5'd10; min_load = 6'd59;
    cycle();
    load_en = 0;
    for (int i = 0; i < 59 * C + (C - 1); i++) cycle();
    checks++;
    if (hour !== 5'd10 || min !== 6'd59 || sec !== 6'd59 || m_p != C - 1) begin
      errors++;
      $display("FAIL wrapload_setup got %0d:%0d:%0d p=%0d want 10:59:59 p=%0d", hour, min, sec, m_p, C - 1);
    end
    load_en = 1; hour_load = 5'd7; min_load = 6'd30;
    cycle();
    load_en = 0;
    checks++;
    if (observed() !== {5'd7, 6'd30, 6'd0, 6'b000010}) begin
      errors++;
      $display("FAIL wrapload_result got=%h want=%h", observed(), {5'd7, 6'd30, 6'd0, 6'b000010});
    end
    for (int i = 1; i <= C; i++) begin
      cycle();
      checks++;
      if (sec_tick !== (i == C)) begin
        errors++;
        $display("FAIL wrapload_restart cycle=%0d got tick=%b want %b", i, sec_tick, i == C);
      end
    end
  endtask

  task automatic goto_051020();
    count_en = 1;
    load_en = 1; hour_load = 5'd5; min_load = 6'd10;
    cycle();
    load_en = 0;
    for (int i = 0; i < 20 * C; i++) cycle();
  endtask

  task automatic test_load_err();
    goto_051020();
    checks++;
    if (hour !== 5'd5 || min !== 6'd10 || sec !== 6'd20) begin
      errors++;
      $display("FAIL loaderr_setup got %0d:%0d:%0d want 5:10:20", hour, min, sec);
    end
    load_en = 1; hour_load = 5'd24; min_load = 6'd15;
    cycle();
    load_en = 0;
    checks++;
    if (observed() !== {5'd5, 6'd15, 6'd0, 6'b000011}) begin
      errors++;
      $display("FAIL loaderr_result got=%h want=%h", observed(), {5'd5, 6'd15, 6'd0, 6'b000011});
    end
    cycle();
    checks++;
    if (load_err !== 1'b0) begin
      errors++;
      $display("FAIL loaderr_pulse got=%b want 0", load_err);
    end
  endtask

  task automatic test_reset_with_load();
    goto_051020();
    cycle();
    rst = 1; load_en = 1; hour_load = 5'd12; min_load = 6'd12;
    cycle();
    rst = 0; load_en = 0;
    checks++;
    if (observed() !== 23'b00000_000000_000000_000010) begin
      errors++;
      $display("FAIL rst_over_load got=%h want=%h", observed(), 23'b00000_000000_000000_000010);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      load_en   = ($urandom_range(0, 24) == 0);
      count_en  = ($urandom_range(0, 9) != 0);
      hour_load = 5'($urandom_range(0, 31));
      min_load  = 6'($urandom_range(0, 63));
      if (load_en && $urandom_range(0, 3) == 0) begin
        hour_load = 5'd23; min_load = 6'd59;
      end
      cycle();
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL random cycle=%0d got=%h want=%h", i, observed(), expected());
      end
    end
    rst = 0; load_en = 0;
  endtask

  initial begin
    test_reset();
    test_count();
    test_rollover();
    test_pause();
    test_load_on_wrap();
    test_load_err();
    test_reset_with_load();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rtc_time_counter.md
Name: rtc_time_counter

Overview:
Timekeeping datapath on the receiving end of the clock controller's count/load interface. Consumes time_count_en, load_en and the loaded hour/minute values. Produces the running hour/min/sec fed back to the controller, plus one-cycle carry strobes and a half-second blink flag for the display and chime logic. Contains the 1 Hz prescaler from the system clock.

Parameters:
CYCLES_PER_SEC, 50_000_000, clk cycles per second; legal range ≥2 (benches use 4)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
count_en  in  1  advance time when 1; hold prescaler and time when 0
load_en  in  1  one-cycle load strobe from the controller
hour_load  in  5  hour value to load (0..23)
min_load  in  6  minute value to load (0..59)
hour  out  5  current hour 0..23
min  out  6  current minute 0..59
sec  out  6  current second 0..59
sec_tick  out  1  high for the single cycle in which a new sec value first appears
min_carry  out  1  high with sec_tick when sec wrapped 59→0
hour_carry  out  1  high with sec_tick when min wrapped 59→0
day_rollover  out  1  high with sec_tick when hour wrapped 23→0
half_sec  out  1  1 while prescaler < CYCLES_PER_SEC/2, else 0 (display blink)
load_err  out  1  one-cycle pulse: a load carried an out-of-range field

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: hour, min, sec and prescaler = 0; all strobes = 0; half_sec = 1. Reset overrides load_en and count_en in the same cycle.
- Prescaler: counts 0..CYCLES_PER_SEC-1 while count_en=1.
  - On the edge where it is at CYCLES_PER_SEC-1, it wraps to 0 and advances time on that same edge.
  - The new sec value and sec_tick are visible together in the following cycle. There is no extra latency.
  - count_en=0: prescaler, time and half_sec hold. Prescaler is not cleared. Strobes are 0.
- Time advance:
  - sec +1. At 59, sec → 0 and min +1 with min_carry.
  - min at 59 → 0 and hour +1 with hour_carry.
  - hour at 23 → 0 with day_rollover.
  - All carry strobes are registered alongside sec_tick. All are single-cycle.
- half_sec: registered, always equal to (prescaler < CYCLES_PER_SEC/2) using integer division. Goes 0 on the edge where the prescaler reaches CYCLES_PER_SEC/2. Goes 1 on wrap or load.
- Load (load_en=1, rst=0):
  - Each field is checked independently. hour_load ≤23 is written to hour; min_load ≤59 is written to min.
  - An out-of-range field is ignored: that register keeps its old value and load_err pulses for one cycle.
  - sec ← 0 and prescaler ← 0 on every load, regardless of field validity.
- Load priority:
  - Load takes priority over a same-cycle prescaler wrap. The wrap is discarded: no sec_tick and no carry strobes.
  - Load acts regardless of count_en.
- Width rules: all counters compare against exact terminal values (23/59/59). No modular arithmetic on the full register width. Registers never hold illegal values.
- Feedback loop: the controller computes hour_load/min_load combinationally from hour/min. Hour/min must therefore be direct register outputs with no combinational path from any input.

Decomposition:
- Shared package clock_pkg holds:
  - widths HOUR_W=5, MIN_W=6, SEC_W=6
  - limits MAX_HOUR=23, MAX_MIN=59, MAX_SEC=59
  - the controller mode encodings, so controller, counter and display agree
- One sub-module, tick_prescaler:
  - parameter CYCLES_PER_SEC
  - inputs clk, rst, en, clear
  - outputs wrap (combinational, the cycle before wrap) and half_sec
- rtc_time_counter instantiates tick_prescaler and holds the sec/min/hour cascade, load/validation and strobe registers.

Test Plan:
1. CYCLES_PER_SEC=4. Reset, then count_en=1 → sec_tick every 4th cycle, half_sec pattern 1,1,0,0. After 60 ticks: min=1, sec=0, min_carry high on exactly that tick.
2. Load 23:59, run 60 ticks → 00:00:00. min_carry, hour_carry and day_rollover all high in the same cycle as that sec_tick.
3. At prescaler=2, drop count_en for 10 cycles → sec, prescaler and half_sec frozen, no strobes. Re-enable → sec_tick on the 2nd enabled edge.
4. Time 10:59:59, load_en with 07:30 on the wrap cycle → 07:30:00, prescaler 0, half_sec 1, no sec_tick or carries.
5. Load hour_load=24, min_load=15 from 05:10:20 → hour=5, min=15, sec=0, load_err pulses once.
6. Mid-run at 05:10:20, rst=1 together with load_en=1 → next cycle 00:00:00, all strobes 0, half_sec 1, no load_err.
